memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 19 +
 rtl/memory_responder_ram.sv | 22 ++
 rtl/memory_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/memory_responder_pkg.sv
// Shared definitions for memory_responder: state encoding, default sizing and
// the access-fault rule used by the responder.
package memory_responder_pkg;

  localparam int unsigned DEFAULT_DEPTH       = 256;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  // Misaligned byte address, or word index past the end of storage.
  function automatic logic isFault(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/memory_responder_ram.sv
// Single-port synchronous word RAM: write-enabled store, registered read.
module memory_responder_ram
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // Write on enable; read port always returns the addressed word one edge later.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: one outstanding load/store at a time against a word RAM.
// Wait states per access are compiled in only when MEM_WAIT_STATES_EN is defined.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = DEFAULT_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        rsp_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef MEM_WAIT_STATES_EN
  localparam bit          UseWait = (WAIT_CYCLES != 0);
  localparam int unsigned CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
`else
  // WAIT_CYCLES has no effect in this build.
  localparam bit          UseWait = 1'b0 && (WAIT_CYCLES != 0);
`endif

  state_t        state, stateNext;
  logic          accept, enterRespond;
  logic          latWrite;
  logic [31:0]   latAddr, latWdata;
  logic          curWrite, curFault;
  logic [31:0]   curAddr, curWdata;
  logic          ramWe;
  logic [31:0]   ramQ;
  logic          rspError, rdKeep;
`ifdef MEM_WAIT_STATES_EN
  logic [CW-1:0] waitCnt;
`endif

  assign accept = req_valid && (state == IDLE) && !reset;

  // In IDLE the RAM sees the live request so the no-wait path can read/write
  // on the acceptance edge; afterwards it sees the latched copy.
  assign curWrite = (state == IDLE) ? req_write : latWrite;
  assign curAddr  = (state == IDLE) ? req_addr  : latAddr;
  assign curWdata = (state == IDLE) ? req_wdata : latWdata;
  assign curFault = isFault(curAddr, DEPTH);
  assign ramWe    = enterRespond && curWrite && !curFault;

  memory_responder_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clock(clock),
    .we   (ramWe),
    .addr (curAddr[AW+1:2]),
    .wdata(curWdata),
    .rdata(ramQ)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state decode; flags the edge on which the access is performed.
  always_comb begin
    stateNext    = state;
    enterRespond = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext    = UseWait ? ACCESS : RESPOND;
          enterRespond = !UseWait;
        end
      end
`ifdef MEM_WAIT_STATES_EN
      ACCESS: begin
        if (waitCnt == CW'(1)) begin
          stateNext    = RESPOND;
          enterRespond = 1'b1;
        end
      end
`endif
      RESPOND: begin
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture the request at acceptance.
  always_ff @(posedge clock) begin
    if (accept) begin
      latWrite <= req_write;
      latAddr  <= req_addr;
      latWdata <= req_wdata;
    end
  end

`ifdef MEM_WAIT_STATES_EN
  // Wait-state down-counter, loaded at acceptance and drained in ACCESS.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                  waitCnt <= '0;
    else if (accept)                            waitCnt <= CW'(WAIT_CYCLES);
    else if (state == ACCESS && waitCnt != '0)  waitCnt <= waitCnt - CW'(1);
  end
`endif

  // Response flags: set on entering RESPOND, cleared when consumed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rspError <= 1'b0;
      rdKeep   <= 1'b0;
    end else if (enterRespond) begin
      rspError <= curFault;
      rdKeep   <= !curWrite && !curFault;
    end else if (state == RESPOND && rsp_ready) begin
      rspError <= 1'b0;
      rdKeep   <= 1'b0;
    end
  end

  // RAM read data is held stable in RESPOND because its address and write
  // enable are frozen; rdKeep zeroes it for stores, faults and outside RESPOND.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESPOND);
  assign rsp_error = rspError;
  assign rsp_rdata = rdKeep ? ramQ : '0;

endmodule
